pipe_stage_reg: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake, an optional two-entry skid buffer, synchronous flush and a saturating stall counter. It replaces the fixed-field, always-advancing inter-stage registers (IF/ID through MEM/WB) with one generic block. Each instance carries an arbitrary packed payload, for example {cmp_out, alu_out, rdata, pc} = 97 bits at the MEM/WB boundary. Back-pressure from a stalled downstream stage is absorbed without a combinational ready path when SKID=1.

---
 rtl/pipe_stage_reg.sv | 129 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with a valid/ready handshake, an optional
// two-entry skid buffer, synchronous flush and a saturating stall counter.
module pipe_stage_reg #(
  parameter int unsigned WIDTH = 97,
  parameter int unsigned SKID  = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  assign out_valid = (occupancy != 2'd0);

  if (SKID != 0) begin : g_skid
    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             ready_q;
    logic             accept;
    logic             rel;

    assign accept    = in_valid & ready_q;
    assign rel       = out_valid & out_ready;
    assign in_ready  = ready_q;
    assign out_data  = main_q;
    assign occupancy = state_q;

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = EMPTY;
        main_d  = '0;
        skid_d  = '0;
      end else begin
        case (state_q)
          EMPTY: begin
            if (accept) begin
              state_d = ONE;
              main_d  = in_data;
            end
          end
          ONE: begin
            if (accept && rel) begin
              main_d = in_data;
            end else if (accept) begin
              state_d = FULL;
              skid_d  = in_data;
            end else if (rel) begin
              state_d = EMPTY;
            end
          end
          FULL: begin
            if (rel) begin
              state_d = ONE;
              main_d  = skid_q;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
    end

    // in_ready is registered from the next state so it never depends on out_ready
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
        ready_q <= 1'b1;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        ready_q <= (state_d != FULL);
      end
    end
  end else begin : g_noskid
    logic             valid_q;
    logic [WIDTH-1:0] main_q;
    logic             accept;

    assign in_ready  = ~valid_q | out_ready;
    assign accept    = in_valid & in_ready;
    assign out_data  = main_q;
    assign occupancy = {1'b0, valid_q};

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        valid_q <= 1'b0;
        main_q  <= '0;
      end else if (flush) begin
        valid_q <= 1'b0;
        main_q  <= '0;
      end else if (accept) begin
        valid_q <= 1'b1;
        main_q  <= in_data;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Counts back-pressured cycles even while flushing; only reset clears it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised scoreboard bench for pipe_stage_reg: dut0 uses the skid buffer,
// dut1 is the single-register variant with a 2-bit stall counter.
module tb_pipe_stage_reg;

  localparam int W = 97;

  logic          clk;
  logic          reset;
  logic          flush     [2];
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [W-1:0]  in_data   [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [W-1:0]  out_data  [2];
  logic [1:0]    occ       [2];
  logic [15:0]   stall0;
  logic [1:0]    stall1;

  int            checks_total;
  int            checks_passed;

  // Reference model: held entries as a tiny ordered array per instance
  logic [W-1:0]  mdata  [2][2];
  logic [W-1:0]  mhead  [2];
  int            mcount [2];
  int            mstall [2];
  int            stall_max [2];
  logic [W-1:0]  sb0 [$];
  logic [W-1:0]  sb1 [$];

  pipe_stage_reg #(.WIDTH(W), .SKID(1), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .occupancy(occ[0]), .stall_cnt(stall0)
  );

  pipe_stage_reg #(.WIDTH(W), .SKID(0), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .occupancy(occ[1]), .stall_cnt(stall1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic modelReady(input int sel);
    if (sel == 0) return (mcount[0] != 2);
    return (mcount[1] == 0) || out_ready[1];
  endfunction

  function automatic logic [15:0] dutStall(input int sel);
    if (sel == 0) return stall0;
    return {14'd0, stall1};
  endfunction

  task automatic checkOutput(input int sel);
    checkValue($sformatf("dut%0d_occupancy", sel), occ[sel], mcount[sel]);
    checkValue($sformatf("dut%0d_out_valid", sel), out_valid[sel], mcount[sel] > 0);
    checkValue($sformatf("dut%0d_out_data", sel), out_data[sel], mhead[sel]);
    checkValue($sformatf("dut%0d_in_ready", sel), in_ready[sel], modelReady(sel));
    checkValue($sformatf("dut%0d_stall_cnt", sel), dutStall(sel), mstall[sel]);
  endtask

  task automatic modelReset();
    for (int s = 0; s < 2; s++) begin
      mcount[s] = 0;
      mhead[s]  = '0;
      mstall[s] = 0;
      in_valid[s]  = 1'b0;
      in_data[s]   = '0;
      out_ready[s] = 1'b1;
      flush[s]     = 1'b0;
    end
    sb0.delete();
    sb1.delete();
  endtask

  // Drives one cycle, pushes the expected beat, advances the model, then checks
  task automatic applyStimulus(input int sel, input logic v, input logic [W-1:0] d,
                               input logic ordy, input logic fl, output logic acc);
    logic rel;
    logic stl;
    in_valid[sel]  = v;
    in_data[sel]   = d;
    out_ready[sel] = ordy;
    flush[sel]     = fl;
    acc = v && modelReady(sel) && !fl;
    rel = (mcount[sel] > 0) && ordy && !fl;
    stl = (mcount[sel] > 0) && !ordy;
    if (fl) begin
      if (sel == 0) sb0.delete(); else sb1.delete();
    end else if (acc) begin
      if (sel == 0) sb0.push_back(d); else sb1.push_back(d);
    end
    @(posedge clk);
    if (fl) begin
      mcount[sel] = 0;
      mhead[sel]  = '0;
    end else begin
      if (rel) begin
        mdata[sel][0] = mdata[sel][1];
        mcount[sel]--;
      end
      if (acc) begin
        mdata[sel][mcount[sel]] = d;
        mcount[sel]++;
      end
      if (mcount[sel] > 0) mhead[sel] = mdata[sel][0];
    end
    if (stl && mstall[sel] < stall_max[sel]) mstall[sel]++;
    #1;
    flush[sel] = 1'b0;
    checkOutput(sel);
  endtask

  task automatic drain(input int sel);
    logic acc;
    for (int i = 0; i < 10 && mcount[sel] != 0; i++) applyStimulus(sel, 1'b0, '0, 1'b1, 1'b0, acc);
    applyStimulus(sel, 1'b0, '0, 1'b1, 1'b0, acc);
  endtask

  task automatic sendBeat(input int sel, input logic [W-1:0] d, input logic ordy);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) applyStimulus(sel, 1'b1, d, ordy, 1'b0, acc);
    if (!acc) begin
      checks_total++;
      $display("[TB] FAIL dut%0d_accept_timeout: beat %0h not taken, required acceptance", sel, d);
    end
  endtask

  // Scoreboard monitors: compare every released beat against the expected order
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset && !flush[0] && out_valid[0] && out_ready[0]) begin
      if (sb0.size() == 0) begin
        checks_total++;
        $display("[TB] FAIL dut0_unexpected_release: got %0h, required no output", out_data[0]);
      end else begin
        e = sb0.pop_front();
        checkValue("dut0_release_data", out_data[0], e);
      end
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset && !flush[1] && out_valid[1] && out_ready[1]) begin
      if (sb1.size() == 0) begin
        checks_total++;
        $display("[TB] FAIL dut1_unexpected_release: got %0h, required no output", out_data[1]);
      end else begin
        e = sb1.pop_front();
        checkValue("dut1_release_data", out_data[1], e);
      end
    end
  end

  initial begin
    logic         acc;
    logic [W-1:0] rd;
    logic [W-1:0] nxt;
    checks_total  = 0;
    checks_passed = 0;
    stall_max[0]  = 65535;
    stall_max[1]  = 3;
    reset = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput(0);
    checkOutput(1);

    $display("[TB] streaming through skid stage");
    for (int i = 1; i <= 8; i++) applyStimulus(0, 1'b1, W'(i), 1'b1, 1'b0, acc);
    drain(0);
    checkValue("stream_stall_cnt", stall0, 16'd0);

    $display("[TB] skid absorb");
    applyStimulus(0, 1'b1, W'('hA), 1'b1, 1'b0, acc);
    nxt = W'('hB);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1'b1, nxt, 1'b0, 1'b0, acc);
      if (acc) nxt = nxt + 1'b1;
    end
    checkValue("skid_occupancy", occ[0], 2'd2);
    checkValue("skid_in_ready", in_ready[0], 1'b0);
    checkValue("skid_stall_cnt", stall0, 16'd3);
    sendBeat(0, nxt, 1'b1);
    drain(0);

    $display("[TB] flush while full");
    applyStimulus(0, 1'b1, W'('h11), 1'b0, 1'b0, acc);
    applyStimulus(0, 1'b1, W'('h22), 1'b0, 1'b0, acc);
    applyStimulus(0, 1'b1, W'('h33), 1'b0, 1'b1, acc);
    checkValue("flush_occupancy", occ[0], 2'd0);
    checkValue("flush_out_valid", out_valid[0], 1'b0);
    checkValue("flush_out_data", out_data[0], '0);
    drain(0);

    $display("[TB] random traffic, skid stage");
    for (int i = 0; i < 300; i++) begin
      rd = {1'($urandom()), $urandom(), $urandom(), $urandom()};
      applyStimulus(0, $urandom_range(3, 0) != 0, rd, $urandom_range(2, 0) != 0,
                    $urandom_range(31, 0) == 0, acc);
    end
    drain(0);

    $display("[TB] single-register back-pressure");
    applyStimulus(1, 1'b1, W'('h55), 1'b0, 1'b0, acc);
    applyStimulus(1, 1'b1, W'('h77), 1'b0, 1'b0, acc);
    checkValue("noskid_in_ready_low", in_ready[1], 1'b0);
    checkValue("noskid_hold_data", out_data[1], W'('h55));
    applyStimulus(1, 1'b1, W'('h66), 1'b1, 1'b0, acc);
    checkValue("noskid_swap_data", out_data[1], W'('h66));
    checkValue("noskid_swap_occ", occ[1], 2'd1);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1'b0, '0, 1'b0, 1'b0, acc);
    checkValue("stall_saturation", stall1, 2'd3);
    for (int i = 0; i < 200; i++) begin
      rd = {1'($urandom()), $urandom(), $urandom(), $urandom()};
      applyStimulus(1, $urandom_range(3, 0) != 0, rd, $urandom_range(2, 0) != 0,
                    $urandom_range(31, 0) == 0, acc);
    end
    drain(1);

    $display("[TB] asynchronous reset while full");
    applyStimulus(0, 1'b1, W'('hC1), 1'b0, 1'b0, acc);
    applyStimulus(0, 1'b1, W'('hC2), 1'b0, 1'b0, acc);
    checkValue("pre_reset_occupancy", occ[0], 2'd2);
    #2;
    reset = 1'b0;
    #1;
    checkValue("async_reset_out_valid", out_valid[0], 1'b0);
    checkValue("async_reset_occupancy", occ[0], 2'd0);
    checkValue("async_reset_stall_cnt", stall0, 16'd0);
    checkValue("async_reset_out_data", out_data[0], '0);
    modelReset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput(0);
    checkOutput(1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, W'('hD0 + i), 1'b1, 1'b0, acc);
    drain(0);

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
